// File: rtl/aes_invmc_colseq.sv
// aes_invmc_colseq: column-serial InvMixColumns sequencer.
// A whole state block is accepted, then one 32-bit column per cycle goes
// through a single aesinvMC core and is written back in place; the finished
// block is presented downstream until it is taken.
// Optional feature macro: AES_INVMC_LASTSKIP_EN adds in_last, which makes the
// block pass through unmodified (final decryption round has no InvMixColumns).

// Combinational InvMixColumns on one column, GF(2^8) modulo 0x11B.
module aesinvMC (
  input  logic [7:0] b0,
  input  logic [7:0] b1,
  input  logic [7:0] b2,
  input  logic [7:0] b3,
  output logic [7:0] a0,
  output logic [7:0] a1,
  output logic [7:0] a2,
  output logic [7:0] a3
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // 9, 11, 13, 14 built from x*2, x*4, x*8
  function automatic logic [7:0] m9(input logic [7:0] x);
    return xt(xt(xt(x))) ^ x;
  endfunction
  function automatic logic [7:0] m11(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(x) ^ x;
  endfunction
  function automatic logic [7:0] m13(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
  endfunction
  function automatic logic [7:0] m14(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
  endfunction

  // circulant matrix rows (14 11 13 9)
  always_comb begin
    a0 = m14(b0) ^ m11(b1) ^ m13(b2) ^ m9(b3);
    a1 = m9(b0)  ^ m14(b1) ^ m11(b2) ^ m13(b3);
    a2 = m13(b0) ^ m9(b1)  ^ m14(b2) ^ m11(b3);
    a3 = m11(b0) ^ m13(b1) ^ m9(b2)  ^ m14(b3);
  end
endmodule

module aes_invmc_colseq #(
  parameter int NCOL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NCOL-1:0] in_data,
`ifdef AES_INVMC_LASTSKIP_EN
  input  logic              in_last,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NCOL-1:0] out_data
);
  if (!(NCOL == 4 || NCOL == 6 || NCOL == 8)) begin : g_bad_ncol
    $error("aes_invmc_colseq: NCOL must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [NCOL-1:0][31:0]    st;
  logic [2:0]               cnt;
  logic                     rdy_q;
  logic                     vld_q;
  logic [31:0]              col_in;
  logic [31:0]              mc_out;
  logic [31:0]              col_wr;
`ifdef AES_INVMC_LASTSKIP_EN
  logic                     skip_q;
`endif

  // select the column currently being processed
  always_comb begin
    col_in = '0;
    for (int i = 0; i < NCOL; i++)
      if (cnt == 3'(i)) col_in = st[i];
  end

  aesinvMC u_mc (
    .b0(col_in[7:0]),   .b1(col_in[15:8]),
    .b2(col_in[23:16]), .b3(col_in[31:24]),
    .a0(mc_out[7:0]),   .a1(mc_out[15:8]),
    .a2(mc_out[23:16]), .a3(mc_out[31:24])
  );

  // write-back value: transformed column, or the original on a last-round block
  always_comb begin
`ifdef AES_INVMC_LASTSKIP_EN
    col_wr = skip_q ? col_in : mc_out;
`else
    col_wr = mc_out;
`endif
  end

  // sequencer FSM; rdy_q/vld_q are the registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      st     <= '0;
      cnt    <= '0;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
`ifdef AES_INVMC_LASTSKIP_EN
      skip_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid && rdy_q) begin
          st     <= in_data;
          cnt    <= '0;
          rdy_q  <= 1'b0;
          state  <= RUN;
`ifdef AES_INVMC_LASTSKIP_EN
          skip_q <= in_last;
`endif
        end
        RUN: begin
          for (int i = 0; i < NCOL; i++)
            if (cnt == 3'(i)) st[i] <= col_wr;
          // counter parks on the last column instead of wrapping
          if (cnt == 3'(NCOL-1)) begin
            state <= DONE;
            vld_q <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // handshakes are suppressed for the whole time reset is asserted
  assign in_ready  = rdy_q & ~rst;
  assign out_valid = vld_q & ~rst;
  assign out_data  = st;
endmodule

// File: tb/tb_aes_invmc_colseq.sv
// Self-checking bench for aes_invmc_colseq (NCOL=4 and NCOL=8 instances).
module tb_aes_invmc_colseq;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last, out_valid, out_ready;
  logic [127:0] in_data, out_data;
  logic         in_valid8, in_ready8, out_valid8, out_ready8;
  logic [255:0] in_data8, out_data8;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  aes_invmc_colseq #(.NCOL(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
`ifdef AES_INVMC_LASTSKIP_EN
    .in_last(in_last),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  aes_invmc_colseq #(.NCOL(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8),
`ifdef AES_INVMC_LASTSKIP_EN
    .in_last(1'b0),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] c);
    logic [7:0] coef [4] = '{8'd14, 8'd11, 8'd13, 8'd9};
    logic [31:0] r = '0;
    for (int row = 0; row < 4; row++)
      for (int j = 0; j < 4; j++)
        r[8*row +: 8] ^= gmul(coef[(j - row + 4) % 4], c[8*j +: 8]);
    return r;
  endfunction

  function automatic logic [255:0] ref_blk(input logic [255:0] d, input int n);
    logic [255:0] r = '0;
    for (int c = 0; c < n; c++) r[32*c +: 32] = ref_col(d[32*c +: 32]);
    return r;
  endfunction

  function automatic logic [31:0] col(input logic [7:0] b0, b1, b2, b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // present a block and step through its acceptance edge
  task automatic send(input logic [127:0] d, input logic lst);
    int n = 0;
    in_data = d; in_last = lst; in_valid = 1'b1;
    while (!in_ready && n < 40) begin step(); n++; end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_data  = rnd128();   // must not disturb the block in flight
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
  endtask

  task automatic finish_out();
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
  endtask

  task automatic run_blk(input string nm, input logic [127:0] d, input logic lst,
                         input logic [127:0] exp);
    int n;
    send(d, lst);
    wait_out(n);
    chk({nm, "_lat"}, n, 4);
    chk({nm, "_data"}, out_data, exp);
    finish_out();
  endtask

  typedef struct {
    logic [127:0] d;
    logic [127:0] e;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int n;
    logic [127:0] d1, d2;
    logic [127:0] bb [3];
    int acc [3];

    tbl[0].d = {col(8'hc6,8'hc6,8'hc6,8'hc6), col(8'h01,8'h01,8'h01,8'h01),
                col(8'h9f,8'hdc,8'h58,8'h9d), col(8'h8e,8'h4d,8'ha1,8'hbc)};
    tbl[0].e = {col(8'hc6,8'hc6,8'hc6,8'hc6), col(8'h01,8'h01,8'h01,8'h01),
                col(8'hf2,8'h0a,8'h22,8'h5c), col(8'hdb,8'h13,8'h53,8'h45)};
    tbl[1].d = '0;
    tbl[1].e = '0;
    tbl[2].d = {32'hffffffff, 32'h34343434, 32'h12121212, col(8'hd5,8'hd5,8'hd7,8'hd6)};
    tbl[2].e = {32'hffffffff, 32'h34343434, 32'h12121212, col(8'hd4,8'hd4,8'hd4,8'hd5)};
    tbl[3].d = {col(8'h8e,8'h4d,8'ha1,8'hbc), col(8'h9f,8'hdc,8'h58,8'h9d),
                32'haaaaaaaa, 32'h01010101};
    tbl[3].e = {col(8'hdb,8'h13,8'h53,8'h45), col(8'hf2,8'h0a,8'h22,8'h5c),
                32'haaaaaaaa, 32'h01010101};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;

    // reset state
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0; #1;
    chk("post_rst_ready", in_ready, 1);

    // table vectors
    for (int i = 0; i < 4; i++) run_blk($sformatf("tbl%0d", i), tbl[i].d, 1'b0, tbl[i].e);

    // random blocks against the model
    for (int i = 0; i < 12; i++) begin
      d1 = rnd128();
      run_blk($sformatf("rnd%0d", i), d1, 1'b0, ref_blk({128'b0, d1}, 4));
    end

    // backpressure: DONE held 10 cycles with a new block waiting
    d1 = rnd128(); d2 = rnd128();
    send(d1, 1'b0);
    wait_out(n);
    chk("bp_lat", n, 4);
    in_data = d2; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_data", out_data, ref_blk({128'b0, d1}, 4));
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("bp_taken", in_ready, 0);
    wait_out(n);
    chk("bp2_lat", n, 4);
    chk("bp2_data", out_data, ref_blk({128'b0, d2}, 4));
    finish_out();

    // back-to-back: accepts NCOL+2 apart
    for (int k = 0; k < 3; k++) bb[k] = rnd128();
    in_data = bb[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!in_ready && n < 40) begin step(); n++; end
      chk("b2b_ready", in_ready, 1);
      acc[k] = cyc;
      step();
      if (k < 2) in_data = bb[k+1]; else in_valid = 1'b0;
      wait_out(n);
      chk($sformatf("b2b%0d_data", k), out_data, ref_blk({128'b0, bb[k]}, 4));
    end
    step(); out_ready = 1'b0;
    chk("b2b_gap01", acc[1] - acc[0], 6);
    chk("b2b_gap12", acc[2] - acc[1], 6);

    // reset in the middle of a block (cnt==2)
    send(rnd128(), 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_ready", in_ready, 0);
    rst = 1'b0; #1;
    chk("mrst_ready_after", in_ready, 1);
    run_blk("mrst_fresh", tbl[0].d, 1'b0, tbl[0].e);

`ifdef AES_INVMC_LASTSKIP_EN
    // last-round blocks pass through unchanged with the same latency
    run_blk("last_spec", tbl[0].d, 1'b1, tbl[0].d);
    d1 = rnd128();
    run_blk("last_rnd", d1, 1'b1, d1);
    run_blk("after_last", tbl[0].d, 1'b0, tbl[0].e);
`endif

    // NCOL=8 instance
    for (int t = 0; t < 2; t++) begin
      logic [255:0] d8, e8;
      if (t == 0) begin
        d8 = {{7{32'h01010101}}, col(8'hd5,8'hd5,8'hd7,8'hd6)};
        e8 = {{7{32'h01010101}}, col(8'hd4,8'hd4,8'hd4,8'hd5)};
      end else begin
        d8 = {rnd128(), rnd128()};
        e8 = ref_blk(d8, 8);
      end
      in_data8 = d8; in_valid8 = 1'b1;
      n = 0;
      while (!in_ready8 && n < 40) begin step(); n++; end
      chk("n8_ready", in_ready8, 1);
      step();
      in_valid8 = 1'b0; in_data8 = '0;
      n = 0;
      while (!out_valid8 && n < 40) begin step(); n++; end
      chk($sformatf("n8_%0d_lat", t), n, 8);
      chk($sformatf("n8_%0d_data", t), out_data8, e8);
      out_ready8 = 1'b1; step(); out_ready8 = 1'b0;
      chk("n8_drop", out_valid8, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_invmc_colseq.md
# aes_invmc_colseq

Column-serial InvMixColumns sequencer for the decryption datapath. Accepts a full state block over a valid/ready handshake, streams it one 32-bit column per cycle through the combinational `aesinvMC` core, and writes each result back into an internal state register. It then presents the transformed block downstream. It sits between the InvSubBytes/AddRoundKey stage (upstream) and the next inverse round (downstream).

## Interface
- `NCOL`, default 4: number of 32-bit columns per block. Legal values are 4, 6 and 8; any other value is a synthesis-time error.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream block valid.
- `in_ready` output 1: block accepted when `in_valid & in_ready` at a rising edge.
- `in_data` input 32*NCOL: column c is `in_data[32c+31:32c]`; byte r of column c is `[32c+8r+7:32c+8r]` and maps to `b_r` of the core.
- `in_last` input 1: present only when `AES_INVMC_LASTSKIP_EN` is defined. Sampled with `in_data`.
- `out_valid` output 1: result block valid.
- `out_ready` input 1: downstream accept.
- `out_data` output 32*NCOL: result block, same column/byte mapping as `in_data`; byte `a_r` maps to byte r.

## Operation
- State register `st` (32*NCOL bits), column counter `cnt` (3 bits), FSM states IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On input handshake: `st` <= `in_data`, `cnt` <= 0, go to RUN.
- RUN:
  - `in_ready`=0, `out_valid`=0.
  - Each cycle, column `cnt` of `st` is fed to `aesinvMC`, and the core result is written to the same column of `st`.
  - `cnt` <= `cnt`+1. When `cnt`==NCOL-1, go to DONE. The counter never wraps past NCOL-1.
- DONE:
  - `out_valid`=1, `out_data`=`st`, `in_ready`=0.
  - On `out_ready`=1, go to IDLE.
  - While `out_ready`=0, `st` and `out_data` hold stable indefinitely.
- `out_data` is driven directly from `st` in every state. Downstream samples it only when `out_valid`=1.
- Inputs presented while `in_ready`=0 are ignored. `in_data` changes during RUN/DONE have no effect.
- Arithmetic is GF(2^8) with polynomial 0x11B, supplied entirely by `aesinvMC`. Columns do not interact.

## Timing
- Reset (`rst`=1 at a rising edge):
  - FSM goes to IDLE, `st`=0, `cnt`=0.
  - `in_ready`=0 and `out_valid`=0 while `rst` is high. `out_data`=0.
  - `in_ready` rises in the first cycle after `rst` is deasserted.
- Reset asserted in RUN or DONE aborts the block. No partial result is ever flagged valid.
- Latency: input handshake at edge E0 → `out_valid` high in the cycle following edge E0+NCOL (NCOL cycles).
- Throughput: one block per NCOL+2 cycles at best (IDLE accept cycle, NCOL RUN cycles, DONE handshake cycle).
- `out_valid` never drops without a completed output handshake, except on reset.
- Simultaneous `rst` and a handshake: reset wins and the handshake is lost.

## Configuration
- `AES_INVMC_LASTSKIP_EN` defined:
  - The `in_last` port exists and is latched at acceptance.
  - If `in_last`=1, each RUN cycle writes the column back unmodified. This handles the final decryption round, which has no InvMixColumns.
  - FSM sequence and latency are identical whether `in_last` is 0 or 1.
- `AES_INVMC_LASTSKIP_EN` undefined:
  - No `in_last` port.
  - Every block is transformed.

## Test plan
- Reset, then NCOL=4 block with columns (bytes b0..b3) (8e,4d,a1,bc), (9f,dc,58,9d), (01,01,01,01), (c6,c6,c6,c6) → `out_valid` exactly 4 cycles after acceptance. Columns: (db,13,53,45), (f2,0a,22,5c), (01,01,01,01), (c6,c6,c6,c6).
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE while driving `in_valid`=1 with a new block → `out_data` is constant, `in_ready`=0, and the new block is accepted only after the output handshake.
- Back-to-back: `in_valid` and `out_ready` held at 1 for 3 blocks → accepts spaced exactly NCOL+2 cycles apart, and each output is correct.
- Mid-operation reset: assert `rst` for one cycle when `cnt`=2 → `out_valid`=0, `out_data`=0, `in_ready`=0 during reset and 1 on the next cycle. A fresh block then completes correctly.
- With `AES_INVMC_LASTSKIP_EN` and `in_last`=1, block column (8e,4d,a1,bc) → output is unchanged (8e,4d,a1,bc), latency 4.
- NCOL=8, column 0 = (d5,d5,d7,d6) and others = (01,01,01,01) → `out_valid` after 8 cycles. Column 0 = (d4,d4,d4,d5), others unchanged.
